// File: rtl/fifo_uart_pkg.sv
// Shared UART definitions: state encodings and default sizing.
// Kept separate so a receiver can reuse the same constants.
package fifo_uart_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_CNT_WIDTH    = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } tx_state_t;

  // True while a serial bit is on the line and must be timed.
  function automatic logic on_line(input tx_state_t s);
    return (s == START) || (s == DATA) || (s == STOP);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick
// on the last count; clear holds it at zero.
module uart_baud_tick
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(CLKS_PER_BIT - 1);

  logic [CNT_WIDTH-1:0] count;

  assign tick = !clear && (count == LAST);

  // Count one bit period, restarting at zero after each tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a registered-read FIFO, one pop
// per frame: start bit, LSB-first data, stop bit.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_enable,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int IW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT =
    IW'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shnext;
  logic [IW-1:0]         bit_idx;
  logic                  tick;
  logic                  clear;
  logic                  can_start;

  assign clear     = !on_line(state);
  assign shnext    = shreg >> 1;
  assign can_start = enable && !fifo_empty;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  // Frame sequencer with registered line, strobe and status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      shreg            <= '0;
      bit_idx          <= '0;
      tx_serial        <= 1'b1;
      tx_busy          <= 1'b0;
      tx_done          <= 1'b0;
      fifo_read_enable <= 1'b0;
    end else begin
      tx_done          <= 1'b0;
      fifo_read_enable <= 1'b0;
      unique case (state)
        IDLE: begin
          if (can_start) begin
            state            <= FETCH;
            fifo_read_enable <= 1'b1;
            tx_busy          <= 1'b1;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          shreg     <= fifo_data;
          bit_idx   <= '0;
          tx_serial <= 1'b0;
          state     <= START;
        end
        START: begin
          if (tick) begin
            tx_serial <= shreg[0];
            state     <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              tx_serial <= 1'b1;
              state     <= STOP;
            end else begin
              bit_idx   <= bit_idx + IW'(1);
              shreg     <= shnext;
              tx_serial <= shnext[0];
            end
          end
        end
        STOP: begin
          if (tick) begin
            tx_done <= 1'b1;
            if (can_start) begin
              state            <= FETCH;
              fifo_read_enable <= 1'b1;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a queue FIFO model
// and an expected-waveform reference per frame.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;
  localparam int FL  = (DW + 2) * CPB;
  localparam int CPB2 = 2;
  localparam int DW2  = 5;
  localparam int FL2  = (DW2 + 2) * CPB2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic fre, line, busy, done;

  logic en2 = 1'b0;
  logic emp2 = 1'b1;
  logic [DW2-1:0] data2 = '0;
  logic fre2, line2, busy2, done2;

  logic [DW-1:0] q[$];
  int checks = 0;
  int errors = 0;
  int pops = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .CNT_WIDTH(16)
  ) dut (
    .clock(clk), .reset(rst), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read_enable(fre), .tx_serial(line),
    .tx_busy(busy), .tx_done(done)
  );

  fifo_uart_tx #(
    .DATA_WIDTH(DW2), .CLKS_PER_BIT(CPB2), .CNT_WIDTH(16)
  ) dut2 (
    .clock(clk), .reset(rst), .enable(en2),
    .fifo_empty(emp2), .fifo_data(data2),
    .fifo_read_enable(fre2), .tx_serial(line2),
    .tx_busy(busy2), .tx_done(done2)
  );

  assign fifo_empty = (q.size() == 0);

  // Registered-read FIFO: data appears the cycle after the pop.
  always @(posedge clk) begin
    if (fre) begin
      pops <= pops + 1;
      if (q.size() > 0) fifo_data <= q.pop_front();
    end
  end

  always @(posedge clk) begin
    if (fre2) data2 <= 5'h1B;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference line waveform: start 0, data LSB first, stop 1.
  function automatic logic [FL-1:0] wave(input logic [DW-1:0] d);
    logic [DW+1:0] b;
    logic [FL-1:0] w;
    b = {1'b1, d, 1'b0};
    for (int k = 0; k < FL; k++) w[k] = b[k / CPB];
    return w;
  endfunction

  task automatic wait_fetch(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fre !== 1'b1 && n < 300);
    chk({tag, "_fetch"}, 64'(fre), 64'(1));
  endtask

  // Called at the negedge of the FETCH cycle.
  task automatic check_frame(input logic [DW-1:0] d,
                             input bit more,
                             input string tag);
    logic [FL-1:0] ol, ob;
    logic od;
    od = 1'b0;
    chk({tag, "_fetch_st"}, 64'({line, busy}), 64'(2'b11));
    @(negedge clk);
    chk({tag, "_load"}, 64'({fre, line}), 64'(2'b01));
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      ol[k] = line;
      ob[k] = busy;
      od = od | done;
    end
    chk({tag, "_line"}, 64'(ol), 64'(wave(d)));
    chk({tag, "_busy"}, 64'(ob), 64'({FL{1'b1}}));
    chk({tag, "_early_done"}, 64'(od), 64'(0));
    @(negedge clk);
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_next"}, 64'({fre, busy}), 64'({more, more}));
  endtask

  initial begin : main
    logic [DW-1:0] r[4];
    logic [DW-1:0] g0, g1;
    logic [FL2-1:0] o2, e2;
    logic [DW2+1:0] b2;
    logic lowseen, freseen;
    int p0;

    repeat (3) @(negedge clk);
    chk("reset_state", 64'({line, busy, done, fre}),
        64'(4'b1000));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", 64'({line, busy}), 64'(2'b10));

    q.push_back(8'hA5);
    enable = 1'b1;
    wait_fetch("a5");
    check_frame(8'hA5, 1'b0, "a5");
    repeat (5) @(negedge clk);
    chk("a5_pops", 64'(pops), 64'(1));
    chk("a5_idle", 64'({line, busy}), 64'(2'b10));

    p0 = pops;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'h3C);
    wait_fetch("burst");
    check_frame(8'h00, 1'b1, "b00");
    check_frame(8'hFF, 1'b1, "bFF");
    check_frame(8'h3C, 1'b0, "b3C");
    repeat (3) @(negedge clk);
    chk("burst_pops", 64'(pops - p0), 64'(3));
    chk("burst_empty", 64'(q.size()), 64'(0));

    p0 = pops;
    for (int i = 0; i < 4; i++) begin
      r[i] = DW'($urandom_range(0, 255));
      q.push_back(r[i]);
    end
    wait_fetch("rnd");
    for (int i = 0; i < 4; i++)
      check_frame(r[i], i < 3, $sformatf("rnd%0d", i));
    repeat (3) @(negedge clk);
    chk("rnd_pops", 64'(pops - p0), 64'(4));

    enable = 1'b0;
    g0 = DW'($urandom_range(0, 255));
    g1 = DW'($urandom_range(0, 255));
    q.push_back(g0);
    q.push_back(g1);
    p0 = pops;
    lowseen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lowseen = lowseen | !line;
    end
    chk("gate_no_pop", 64'(pops - p0), 64'(0));
    chk("gate_line_high", 64'(lowseen), 64'(0));
    enable = 1'b1;
    wait_fetch("gate");
    enable = 1'b0;
    check_frame(g0, 1'b0, "gate_f1");
    lowseen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lowseen = lowseen | !line;
    end
    chk("gate_held_pops", 64'(pops - p0), 64'(1));
    chk("gate_held_q", 64'(q.size()), 64'(1));
    chk("gate_held_line", 64'(lowseen), 64'(0));
    enable = 1'b1;
    wait_fetch("gate2");
    check_frame(g1, 1'b0, "gate_f2");

    p0 = pops;
    lowseen = 1'b0;
    freseen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lowseen = lowseen | !line;
      freseen = freseen | fre;
    end
    chk("empty_no_pop", 64'(freseen), 64'(0));
    chk("empty_line", 64'(lowseen), 64'(0));

    q.push_back(8'h55);
    wait_fetch("mrst");
    @(negedge clk);
    repeat (CPB * 4 + 1) @(negedge clk);
    chk("mrst_bit3", 64'({line, busy}), 64'(2'b01));
    #2 rst = 1'b1;
    #1 chk("mrst_async", 64'({line, busy, done, fre}),
           64'(4'b1000));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p0 = pops;
    lowseen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      lowseen = lowseen | !line | busy;
    end
    chk("mrst_no_resend", 64'(pops - p0), 64'(0));
    chk("mrst_quiet", 64'(lowseen), 64'(0));

    en2 = 1'b1;
    emp2 = 1'b0;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (fre2 !== 1'b1 && n < 100);
    end
    chk("sw_fetch", 64'(fre2), 64'(1));
    emp2 = 1'b1;
    @(negedge clk);
    chk("sw_load", 64'({fre2, line2}), 64'(2'b01));
    b2 = {1'b1, 5'h1B, 1'b0};
    for (int k = 0; k < FL2; k++) begin
      @(negedge clk);
      o2[k] = line2;
      e2[k] = b2[k / CPB2];
    end
    chk("sw_line", 64'(o2), 64'(e2));
    @(negedge clk);
    chk("sw_done", 64'({done2, busy2}), 64'(2'b10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each FIFO word and of each serial frame's data field.
REQ-002 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range is 2 to 65535.
REQ-003 Parameter CNT_WIDTH, default 16: width of the bit-period counter; it SHALL hold CLKS_PER_BIT-1.
REQ-004 Port clock, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port enable, input, 1 bit: permits starting new frames.
REQ-007 Port fifo_empty, input, 1 bit: upstream FIFO empty flag.
REQ-008 Port fifo_data, input, DATA_WIDTH bits: upstream FIFO registered read data, valid the cycle after a read strobe.
REQ-009 Port fifo_read_enable, output, 1 bit: pop strobe to the upstream FIFO.
REQ-010 Port tx_serial, output, 1 bit: serial line, idle high.
REQ-011 Port tx_busy, output, 1 bit: high in every state except IDLE.
REQ-012 Port tx_done, output, 1 bit: one-cycle pulse when a stop bit completes.

Function
REQ-013 The FSM SHALL have the states IDLE, FETCH, LOAD, START, DATA and STOP.
REQ-014 IDLE -> FETCH when enable=1 and fifo_empty=0; otherwise the FSM stays in IDLE.
REQ-015 fifo_read_enable SHALL be 1 only while in FETCH, FETCH SHALL last exactly 1 cycle, and there SHALL be exactly one pop per frame.
REQ-016 LOAD SHALL last 1 cycle, capture fifo_data into the shift register at its closing edge, and then go to START.
REQ-017 START, each DATA bit and STOP SHALL each last exactly CLKS_PER_BIT cycles, timed by a counter running 0 to CLKS_PER_BIT-1.
REQ-018 Data bits SHALL be sent LSB first; a bit index runs 0 to DATA_WIDTH-1, and DATA -> STOP after index DATA_WIDTH-1.
REQ-019 tx_serial SHALL be registered: 0 during START, the data bit during DATA, and 1 during STOP, IDLE, FETCH and LOAD.
REQ-020 The first cycle of tx_serial=0 SHALL be the cycle after LOAD; the frame is (DATA_WIDTH+2)*CLKS_PER_BIT cycles long.
REQ-021 At the end of STOP: tx_done=1 for 1 cycle; the next state is FETCH if enable=1 and fifo_empty=0, otherwise IDLE.
REQ-022 Back-to-back frames SHALL therefore have exactly 2 idle-high cycles between them (FETCH and LOAD).
REQ-023 Deasserting enable mid-frame SHALL NOT abort the frame; it blocks only the next FETCH.
REQ-024 fifo_empty and fifo_data SHALL be ignored outside IDLE, end of STOP, and LOAD respectively.
REQ-025 The bit-period counter SHALL reset to 0 on every state change and never wrap past CLKS_PER_BIT-1.

Reset
REQ-026 Reset SHALL take effect immediately, independent of clock: state=IDLE, tx_serial=1, tx_busy=0, tx_done=0, fifo_read_enable=0, counters=0, shift register=0.
REQ-027 Reset mid-frame SHALL abandon the frame with the line high at once; the word already popped is discarded and SHALL NOT be resent.
REQ-028 After reset release, the first frame SHALL start only via the IDLE -> FETCH rule.

Structure
REQ-029 The state encodings (3-bit) and the default parameter values SHALL live in shared package fifo_uart_pkg for reuse by a future receiver.
REQ-030 The bit-period counter SHALL be a sub-module uart_baud_tick: clock, reset, clear input, 1-cycle tick output every CLKS_PER_BIT cycles.
REQ-031 The FSM, shift register and output registers SHALL reside in fifo_uart_tx.

Verification (bench models a 1-cycle-latency registered-read FIFO; CLKS_PER_BIT=4)
REQ-032 Single byte: push 0xA5, enable=1 -> one fifo_read_enable pulse; tx_serial = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done 40 cycles after the first low cycle; then IDLE.
REQ-033 Burst: push 0x00, 0xFF, 0x3C with enable held -> 3 frames, exactly 2 high cycles between frames, 3 pops, 3 tx_done pulses, FIFO ends empty.
REQ-034 Enable gating: enable=0 with 2 bytes queued -> no pops and line high; drop enable during frame 1 -> frame 1 completes, frame 2 does not start.
REQ-035 Mid-frame reset: assert reset during DATA bit 3 of 0x55 -> tx_serial=1 and tx_busy=0 in the same cycle; after release with an empty FIFO, no frame.
REQ-036 Empty FIFO: enable=1, fifo_empty=1 for 100 cycles -> fifo_read_enable never 1, tx_serial constantly 1.
REQ-037 Parameter sweep: DATA_WIDTH=5 and CLKS_PER_BIT=2, send 0x1B -> 7-bit frame of 14 cycles, bits 0,1,1,0,1,1,1.
